// File: rtl/lm70_frame_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : lm70_frame_reader_if
// Description : Signal bundle between the LM70 frame reader and its
//               surroundings: the serial sensor pins, the frame enable and the
//               decoded temperature result bus.
//               master - the frame reader (drives CS/SCK and the results)
//               slave  - the sensor / display side (drives en_i and sio_i)
// Revision    : 1.0 - initial release
// ============================================================================
interface lm70_frame_reader_if;
    logic        en_i;       // run frames back-to-back while high
    logic        sio_i;      // LM70 SI/O, MSB first
    logic        cs_o;       // chip select, active-low
    logic        sck_o;      // SPI clock, idles low
    logic [15:0] frame_o;    // last captured raw frame
    logic [8:0]  temp_c_o;   // signed integer degC of last good frame
    logic [7:0]  temp_u8_o;  // temp_c_o clamped to 0..255
    logic        valid_o;    // one-cycle frame-complete strobe
    logic        err_o;      // frame integrity failure, with valid_o
    logic        busy_o;     // reader not idle

    modport master (
        input  en_i, sio_i,
        output cs_o, sck_o, frame_o, temp_c_o, temp_u8_o, valid_o, err_o, busy_o
    );

    modport slave (
        output en_i, sio_i,
        input  cs_o, sck_o, frame_o, temp_c_o, temp_u8_o, valid_o, err_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/lm70_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : lm70_frame_reader
// Description : SPI master reading full 16-bit frames from an LM70 sensor.
//               Generates CS/SCK from clk, captures the frame MSB first and
//               publishes the signed integer degC value plus a clamped byte.
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous reset, active-high
//               bus.en_i   - frames run back-to-back while high (IDLE only)
//               bus.sio_i  - sensor serial data
//               bus.cs_o / bus.sck_o           - SPI chip select / clock
//               bus.frame_o                    - last raw frame
//               bus.temp_c_o / bus.temp_u8_o   - last good temperature
//               bus.valid_o / bus.err_o        - completion / integrity strobes
//               bus.busy_o                     - state != IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module lm70_frame_reader #(
    parameter int CLK_DIV    = 2,   // SCK half-period in clk cycles (>=1)
    parameter int GAP_CYCLES = 16   // CS-high cycles between frames (>=1)
) (
    input  logic                   clk,
    input  logic                   rst,
    lm70_frame_reader_if.master    bus
);

    // One counter serves both the SCK phase timer and the inter-frame gap.
    localparam int C_CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int C_CW      = $clog2(C_CNT_MAX + 1);
    localparam logic [C_CW-1:0] C_DIV_LAST = C_CW'(CLK_DIV - 1);
    localparam logic [C_CW-1:0] C_GAP_LAST = C_CW'(GAP_CYCLES - 1);
    localparam logic [C_CW-1:0] C_CNT_ONE  = C_CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [C_CW-1:0]   cnt_q,     cnt_d;
    logic [3:0]        bit_q,     bit_d;
    logic              sck_q,     sck_d;
    logic [15:0]       shift_q,   shift_d;
    logic [15:0]       frame_q,   frame_d;
    logic [8:0]        temp_c_q,  temp_c_d;
    logic [7:0]        temp_u8_q, temp_u8_d;
    logic              valid_q,   valid_d;
    logic              err_q,     err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sck_q     <= 1'b0;
            shift_q   <= '0;
            frame_q   <= '0;
            temp_c_q  <= '0;
            temp_u8_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sck_q     <= sck_d;
            shift_q   <= shift_d;
            frame_q   <= frame_d;
            temp_c_q  <= temp_c_d;
            temp_u8_q <= temp_u8_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sck_d     = sck_q;
        shift_d   = shift_q;
        frame_d   = frame_q;
        temp_c_d  = temp_c_q;
        temp_u8_d = temp_u8_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                sck_d = 1'b0;
                if (bus.en_i) begin
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (cnt_q == C_DIV_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end

            SHIFT: begin
                if (cnt_q == C_DIV_LAST) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        // Rising SCK: the sensor's bit is stable, take it.
                        sck_d   = 1'b1;
                        shift_d = {shift_q[14:0], bus.sio_i};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            // shift_q already holds all 16 bits here.
                            state_d = GAP;
                            bit_d   = '0;
                            frame_d = shift_q;
                            valid_d = 1'b1;
                            err_d   = (shift_q[4:2] != 3'b111);
                            if (shift_q[4:2] == 3'b111) begin
                                temp_c_d  = shift_q[15:7];
                                temp_u8_d = shift_q[15] ? 8'd0 : shift_q[14:7];
                            end
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end

            GAP: begin
                if (cnt_q == C_GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // CS and busy decode straight from the state register.
    assign bus.cs_o      = !((state_q == SETUP) || (state_q == SHIFT));
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.sck_o     = sck_q;
    assign bus.frame_o   = frame_q;
    assign bus.temp_c_o  = temp_c_q;
    assign bus.temp_u8_o = temp_u8_q;
    assign bus.valid_o   = valid_q;
    assign bus.err_o     = err_q;

endmodule
`default_nettype wire
